wb_bist_master: RTL

Wishbone initiator that fills a word-addressed memory region with a deterministic pattern, then reads it back and checks it. It drives the same flat Wishbone signal set that `wrapper` exposes around `wb_bram`, so it connects port-for-port to that slave. It is used as the on-chip self-test master for the BRAM controller. It issues incrementing bursts with CTI signalling and handles retry and error terminations.

---
 rtl/wb_bist_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/wb_bist_master.sv
// rtl/wb_bist_master.sv - Wishbone BIST initiator: incrementing-burst pattern fill, then read-back compare.
// Handles retry (one idle cycle, same beat re-issued) and error (abort to FIN) terminations.
module wb_bist_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic [LEN_W-1:0] nwords,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] mismatch_cnt,
  output logic [31:0]      first_fail_adr,
  output logic             bus_err,
  output logic [31:0]      dat_ms,
  input  logic [31:0]      dat_sm,
  output logic [31:0]      adr,
  output logic             cyc,
  output logic             stb,
  output logic             we,
  output logic [3:0]       sel,
  output logic [2:0]       cti,
  output logic [1:0]       bte,
  input  logic             ack,
  input  logic             err,
  input  logic             rty
);

  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, RGAP, FIN} state_e;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_e           state_q;
  logic [LEN_W-1:0] idx_q, nwords_q, mismatch_q;
  logic [31:0]      base_q, seed_q, ffa_q, adr_q, dat_q;
  logic             busy_q, done_q, berr_q, cyc_q, we_q, wr_phase_q;
  logic [3:0]       sel_q;
  logic [2:0]       cti_q;

  logic [31:0]      base_sel, seed_sel, beat_adr, beat_dat, exp_dat;
  logic [LEN_W-1:0] len_sel, tgt;
  logic [2:0]       beat_cti;
  logic             last;

  // In IDLE the first beat is built straight from the inputs so it is on the bus one edge after start.
  always_comb begin
    base_sel = (state_q == IDLE) ? (base & 32'hFFFF_FFFC) : base_q;
    seed_sel = (state_q == IDLE) ? seed : seed_q;
    len_sel  = (state_q == IDLE) ? nwords : nwords_q;
    last     = (idx_q == nwords_q - ONE);
    tgt      = '0;
    if (state_q == WRITE || state_q == READ) tgt = idx_q + ONE;
    else if (state_q == RGAP)                tgt = idx_q;
    beat_adr = base_sel + (32'(tgt) << 2);
    beat_dat = seed_sel + 32'(tgt);
    beat_cti = (tgt == len_sel - ONE) ? 3'b111 : 3'b010;
    exp_dat  = seed_q + 32'(idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      nwords_q   <= '0;
      mismatch_q <= '0;
      base_q     <= '0;
      seed_q     <= '0;
      ffa_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      berr_q     <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      wr_phase_q <= 1'b0;
      sel_q      <= 4'h0;
      cti_q      <= 3'b000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mismatch_q <= '0;
            ffa_q      <= '0;
            berr_q     <= 1'b0;
            base_q     <= base_sel;
            seed_q     <= seed;
            nwords_q   <= nwords;
            idx_q      <= '0;
            wr_phase_q <= 1'b1;
            if (nwords == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= WRITE;
              busy_q  <= 1'b1;
              cyc_q   <= 1'b1;
              we_q    <= 1'b1;
              sel_q   <= 4'hF;
              adr_q   <= beat_adr;
              dat_q   <= beat_dat;
              cti_q   <= beat_cti;
            end
          end
        end
        WRITE, READ: begin
          if (err || (ack && last) || (!ack && rty)) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= 4'h0;
            cti_q <= 3'b000;
            adr_q <= '0;
            dat_q <= '0;
          end
          if (err) begin
            berr_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (ack) begin
            if (state_q == READ && dat_sm != exp_dat) begin
              if (mismatch_q != '1) mismatch_q <= mismatch_q + ONE;
              if (mismatch_q == '0) ffa_q <= adr_q;
            end
            if (!last) begin
              idx_q <= idx_q + ONE;
              adr_q <= beat_adr;
              dat_q <= beat_dat;
              cti_q <= beat_cti;
            end else if (state_q == WRITE) begin
              state_q <= GAP;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end else if (rty) begin
            state_q <= RGAP;
          end
        end
        GAP, RGAP: begin
          // GAP restarts at word 0 in the read phase; RGAP re-issues the retried beat in its own phase.
          if (state_q == GAP) begin
            idx_q      <= '0;
            wr_phase_q <= 1'b0;
            we_q       <= 1'b0;
            state_q    <= READ;
          end else begin
            we_q    <= wr_phase_q;
            state_q <= wr_phase_q ? WRITE : READ;
          end
          cyc_q <= 1'b1;
          sel_q <= 4'hF;
          adr_q <= beat_adr;
          dat_q <= beat_dat;
          cti_q <= beat_cti;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch_cnt   = mismatch_q;
  assign first_fail_adr = ffa_q;
  assign bus_err        = berr_q;
  assign dat_ms         = dat_q;
  assign adr            = adr_q;
  assign cyc            = cyc_q;
  assign stb            = cyc_q;
  assign we             = we_q;
  assign sel            = sel_q;
  assign cti            = cti_q;
  assign bte            = 2'b00;

endmodule
